cpu_id: RTL and testbench

- Instruction decoder for the single-issue 13-bit CPU.
- Splits each instruction word into a 5-bit opcode (IN[12:8]) and an 8-bit data field (IN[7:0]).
- Drives every datapath control: PC, ALU, accumulator, register file, data memory and base register.
- All outputs are registered, giving one cycle of latency from IN to controls.

---
 rtl/cpu_id.sv | 189 ++++++++++++++++++
 tb/tb_cpu_id.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_id.sv
// cpu_id: registered instruction decoder driving all datapath controls of the 13-bit CPU
module cpu_id #(
    parameter int WIDTH          = 13,
    parameter int IWIDTH         = 5,
    parameter int REG_F_SEL_SIZE = 4,
    parameter int IN_B_SEL_SIZE  = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [WIDTH-1:0]            IN,
    output logic                        RST,
    output logic                        PC_LD,
    output logic [IWIDTH-2:0]           ALU_OUT,
    output logic [WIDTH-IWIDTH-1:0]     IMM,
    output logic [IN_B_SEL_SIZE-1:0]    IN_B_SEL,
    output logic [REG_F_SEL_SIZE-1:0]   REG_F_SEL,
    output logic                        EN_REG_F,
    output logic [WIDTH-IWIDTH-1:0]     D_MEM_ADDR,
    output logic                        D_MEM_ADDR_MODE,
    output logic                        EN_D_MEM,
    output logic                        EN_ACC,
    output logic                        JMP_MODE,
    output logic [WIDTH-IWIDTH-1:0]     BASE_REG_OFFSET,
    output logic                        BASE_REG_LD,
    output logic [WIDTH-IWIDTH-1:0]     BASE_REG_DATA
);
    localparam int D = WIDTH - IWIDTH;
    localparam logic [IWIDTH-1:0] OP_RST  = 5'b00001, OP_LD   = 5'b00010, OP_ST   = 5'b00011,
                                  OP_LDR  = 5'b00100, OP_STR  = 5'b00101, OP_BAR  = 5'b00110,
                                  OP_JMP  = 5'b00111, OP_JMPO = 5'b01000, OP_LDI  = 5'b01001,
                                  OP_LDAR = 5'b01010, OP_STAR = 5'b01011;
    localparam logic [IWIDTH-2:0] ALU_LOAD = 4'b0001, ALU_XOR = 4'b0010;
    localparam logic [IN_B_SEL_SIZE-1:0] B_IMM = 2'b00, B_REG = 2'b01, B_MEM = 2'b10;
    localparam logic [REG_F_SEL_SIZE-1:0] PORT_SEL = 4'd8;

    logic [IWIDTH-1:0]         op;
    logic [D-1:0]              d;
    logic [REG_F_SEL_SIZE-1:0] r;
    logic                      reg_ok;
    logic                      rst_d, rst_q, pc_ld_d, pc_ld_q, en_reg_f_d, en_reg_f_q;
    logic                      mode_d, mode_q, en_d_mem_d, en_d_mem_q, en_acc_d, en_acc_q;
    logic                      jmp_mode_d, jmp_mode_q, base_ld_d, base_ld_q;
    logic [IWIDTH-2:0]         alu_d, alu_q;
    logic [D-1:0]              imm_d, imm_q, addr_d, addr_q, offset_d, offset_q, base_data_d, base_data_q;
    logic [IN_B_SEL_SIZE-1:0]  in_b_sel_d, in_b_sel_q;
    logic [REG_F_SEL_SIZE-1:0] reg_f_sel_d, reg_f_sel_q;

    // decode the current word; anything not set by its opcode stays 0
    always_comb begin
        op          = IN[WIDTH-1:D];
        d           = IN[D-1:0];
        r           = IN[REG_F_SEL_SIZE-1:0];
        reg_ok      = r <= PORT_SEL;
        rst_d       = 1'b0;
        pc_ld_d     = 1'b0;
        alu_d       = '0;
        imm_d       = '0;
        in_b_sel_d  = B_IMM;
        reg_f_sel_d = '0;
        en_reg_f_d  = 1'b0;
        addr_d      = '0;
        mode_d      = 1'b0;
        en_d_mem_d  = 1'b0;
        en_acc_d    = 1'b0;
        jmp_mode_d  = 1'b0;
        offset_d    = '0;
        base_ld_d   = 1'b0;
        base_data_d = '0;
        case (op)
            OP_RST: rst_d = 1'b1;
            OP_LD: begin
                in_b_sel_d = B_MEM;
                addr_d     = d;
                alu_d      = ALU_LOAD;
                en_acc_d   = 1'b1;
            end
            OP_ST: begin
                addr_d     = d;
                en_d_mem_d = 1'b1;
            end
            OP_LDR: if (reg_ok) begin
                in_b_sel_d  = B_REG;
                reg_f_sel_d = r;
                alu_d       = ALU_LOAD;
                en_acc_d    = 1'b1;
            end
            OP_STR: if (reg_ok) begin
                reg_f_sel_d = r;
                en_reg_f_d  = 1'b1;
            end
            OP_BAR: begin
                base_ld_d   = 1'b1;
                base_data_d = d;
            end
            OP_JMP: begin
                pc_ld_d = 1'b1;
                imm_d   = d;
            end
            OP_JMPO: begin
                pc_ld_d    = 1'b1;
                jmp_mode_d = 1'b1;
                offset_d   = d;
            end
            OP_LDI: begin
                imm_d    = d;
                alu_d    = ALU_LOAD;
                en_acc_d = 1'b1;
            end
            OP_LDAR: begin
                in_b_sel_d = B_MEM;
                mode_d     = 1'b1;
                offset_d   = d;
                alu_d      = ALU_LOAD;
                en_acc_d   = 1'b1;
            end
            OP_STAR: begin
                mode_d     = 1'b1;
                offset_d   = d;
                en_d_mem_d = 1'b1;
            end
            // low three opcode bits 0..4 map onto ALU codes XOR..SUB in order
            5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100: if (reg_ok) begin
                in_b_sel_d  = B_REG;
                reg_f_sel_d = r;
                alu_d       = ALU_XOR + (IWIDTH-1)'(op[2:0]);
                en_acc_d    = 1'b1;
            end
            5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b11100: begin
                imm_d    = d;
                alu_d    = ALU_XOR + (IWIDTH-1)'(op[2:0]);
                en_acc_d = 1'b1;
            end
            default: ;
        endcase
    end

    // register every control; async reset parks the datapath in NOP
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_q       <= 1'b0;
            pc_ld_q     <= 1'b0;
            alu_q       <= '0;
            imm_q       <= '0;
            in_b_sel_q  <= '0;
            reg_f_sel_q <= '0;
            en_reg_f_q  <= 1'b0;
            addr_q      <= '0;
            mode_q      <= 1'b0;
            en_d_mem_q  <= 1'b0;
            en_acc_q    <= 1'b0;
            jmp_mode_q  <= 1'b0;
            offset_q    <= '0;
            base_ld_q   <= 1'b0;
            base_data_q <= '0;
        end else begin
            rst_q       <= rst_d;
            pc_ld_q     <= pc_ld_d;
            alu_q       <= alu_d;
            imm_q       <= imm_d;
            in_b_sel_q  <= in_b_sel_d;
            reg_f_sel_q <= reg_f_sel_d;
            en_reg_f_q  <= en_reg_f_d;
            addr_q      <= addr_d;
            mode_q      <= mode_d;
            en_d_mem_q  <= en_d_mem_d;
            en_acc_q    <= en_acc_d;
            jmp_mode_q  <= jmp_mode_d;
            offset_q    <= offset_d;
            base_ld_q   <= base_ld_d;
            base_data_q <= base_data_d;
        end
    end

    assign RST             = rst_q;
    assign PC_LD           = pc_ld_q;
    assign ALU_OUT         = alu_q;
    assign IMM             = imm_q;
    assign IN_B_SEL        = in_b_sel_q;
    assign REG_F_SEL       = reg_f_sel_q;
    assign EN_REG_F        = en_reg_f_q;
    assign D_MEM_ADDR      = addr_q;
    assign D_MEM_ADDR_MODE = mode_q;
    assign EN_D_MEM        = en_d_mem_q;
    assign EN_ACC          = en_acc_q;
    assign JMP_MODE        = jmp_mode_q;
    assign BASE_REG_OFFSET = offset_q;
    assign BASE_REG_LD     = base_ld_q;
    assign BASE_REG_DATA   = base_data_q;
endmodule

// File: tb/tb_cpu_id.sv
// tb_cpu_id: scoreboard bench for cpu_id against a per-output reference model
module tb_cpu_id;
    typedef struct packed {
        logic       rst;
        logic       pc_ld;
        logic [3:0] alu;
        logic [7:0] imm;
        logic [1:0] bsel;
        logic [3:0] rsel;
        logic       en_reg_f;
        logic [7:0] addr;
        logic       mode;
        logic       en_d_mem;
        logic       en_acc;
        logic       jmp_mode;
        logic [7:0] off;
        logic       bld;
        logic [7:0] bdata;
    } ctl_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [12:0] IN = {5'd9, 8'h0F};
    logic        RST, PC_LD, EN_REG_F, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, JMP_MODE, BASE_REG_LD;
    logic [3:0]  ALU_OUT, REG_F_SEL;
    logic [7:0]  IMM, D_MEM_ADDR, BASE_REG_OFFSET, BASE_REG_DATA;
    logic [1:0]  IN_B_SEL;
    ctl_t        got;
    ctl_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    cpu_id dut (
        .CLK(CLK), .RST_N(RST_N), .IN(IN), .RST(RST), .PC_LD(PC_LD), .ALU_OUT(ALU_OUT), .IMM(IMM),
        .IN_B_SEL(IN_B_SEL), .REG_F_SEL(REG_F_SEL), .EN_REG_F(EN_REG_F), .D_MEM_ADDR(D_MEM_ADDR),
        .D_MEM_ADDR_MODE(D_MEM_ADDR_MODE), .EN_D_MEM(EN_D_MEM), .EN_ACC(EN_ACC), .JMP_MODE(JMP_MODE),
        .BASE_REG_OFFSET(BASE_REG_OFFSET), .BASE_REG_LD(BASE_REG_LD), .BASE_REG_DATA(BASE_REG_DATA)
    );

    assign got = {RST, PC_LD, ALU_OUT, IMM, IN_B_SEL, REG_F_SEL, EN_REG_F, D_MEM_ADDR,
                  D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, JMP_MODE, BASE_REG_OFFSET, BASE_REG_LD, BASE_REG_DATA};

    always #5 CLK = ~CLK;

    // each output derived from the instruction-set table, one field at a time
    function automatic ctl_t model(input logic [12:0] ins);
        ctl_t c;
        int op, r;
        logic [7:0] d;
        bit regf;
        c = '0;
        op = int'(ins[12:8]);
        d = ins[7:0];
        r = int'(ins[3:0]);
        regf = op inside {4, 5, [16:20]};
        if (regf && r > 8) return c;
        c.rst      = op == 1;
        c.pc_ld    = op inside {7, 8};
        c.jmp_mode = op == 8;
        c.en_acc   = op inside {2, 4, 9, 10, [16:20], [24:28]};
        c.en_reg_f = op == 5;
        c.en_d_mem = op inside {3, 11};
        c.bld      = op == 6;
        c.bdata    = (op == 6) ? d : 8'h00;
        c.imm      = (op inside {7, 9, [24:28]}) ? d : 8'h00;
        c.addr     = (op inside {2, 3}) ? d : 8'h00;
        c.mode     = op inside {10, 11};
        c.off      = (op inside {8, 10, 11}) ? d : 8'h00;
        c.rsel     = regf ? 4'(r) : 4'd0;
        c.bsel     = (op inside {2, 10}) ? 2'd2 : (op inside {4, [16:20]}) ? 2'd1 : 2'd0;
        if (op inside {2, 4, 9, 10}) c.alu = 4'd1;
        else if (op >= 16 && op <= 20) c.alu = 4'(op - 14);
        else if (op >= 24 && op <= 28) c.alu = 4'(op - 22);
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic issue(input logic [12:0] ins);
        @(negedge CLK);
        #2;
        IN = ins;
        exp_q.push_back(model(ins));
    endtask

    task automatic issue_n(input logic [12:0] ins, input int n);
        for (int i = 0; i < n; i++) issue(ins);
    endtask

    task automatic mid_reset(input logic [12:0] during, input logic [12:0] at_release);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_clear", 64'(got), 64'd0);
        IN = during;
        @(negedge CLK);
        check("held_in_reset", 64'(got), 64'd0);
        #2;
        IN = at_release;
        RST_N = 1'b1;
        exp_q.push_back(model(at_release));
    endtask

    // monitor: compare every cycle for which a decode is outstanding
    always @(negedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            ctl_t e;
            e = exp_q.pop_front();
            check($sformatf("decode_in_%h", IN), 64'(got), 64'(e));
            check("exclusive_enables", 64'($countones({EN_ACC, EN_REG_F, EN_D_MEM, PC_LD, BASE_REG_LD, RST}) <= 1), 64'd1);
        end
    end

    initial begin
        logic [4:0] ops [0:21];
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28};
        #23;
        check("reset_state", 64'(got), 64'd0);
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        exp_q.push_back(model(IN));
        issue_n({5'd0, 8'h00}, 10);
        issue_n({5'd1, 8'h00}, 10);
        issue_n({5'd2, 8'h09}, 10);
        issue_n({5'd3, 8'h06}, 10);
        issue({5'd4, 8'h02});
        issue({5'd5, 8'h07});
        issue({5'd5, 8'h09});
        issue({5'd5, 8'h08});
        issue({5'd4, 8'hF8});
        issue({5'd16, 8'h0F});
        issue({5'd6, 8'hA1});
        issue({5'd7, 8'h2B});
        issue({5'd8, 8'h0C});
        issue({5'd10, 8'h02});
        issue({5'd11, 8'hFE});
        issue({5'd16, 8'h01});
        issue({5'd17, 8'h03});
        issue({5'd18, 8'h04});
        issue({5'd19, 8'h05});
        issue({5'd20, 8'h06});
        issue({5'd24, 8'h55});
        issue({5'd28, 8'hFF});
        issue({5'd31, 8'hFF});
        issue({5'd12, 8'h33});
        mid_reset({5'd9, 8'h77}, {5'd7, 8'h3C});
        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 21)];
            issue({op, 8'($urandom_range(0, 255))});
            if (i % 97 == 50) mid_reset(13'($urandom), {ops[$urandom_range(0, 21)], 8'($urandom_range(0, 255))});
        end
        repeat (3) @(negedge CLK);
        #3;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
